// File: rtl/debug_display_ctrl_if.sv
// debug_display_ctrl_if: front-panel bus between the debug display controller and the board.
// btn_next   - raw push-button, high = pressed
// show_value - word returned by the debug view mux for view_sel
// view_sel   - debug-view select (1..6)
// an, seg, dp - active-low digit enables, segments {g..a} and decimal point
// frame_tick - one-cycle pulse when a new snapshot is captured
interface debug_display_ctrl_if;
    logic        btn_next;
    logic [31:0] show_value;
    logic [2:0]  view_sel;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
    modport master (output btn_next, show_value, input view_sel, an, seg, dp, frame_tick);
    modport slave  (input btn_next, show_value, output view_sel, an, seg, dp, frame_tick);
endinterface

// File: rtl/debug_display_ctrl.sv
// debug_display_ctrl: debounced view stepping plus 8-digit multiplexed hex display of the selected word.
// clk   - system clock, rising edge
// rst_n - asynchronous active-low reset
// bus   - debug_display_ctrl_if slave: button in, show_value in, view_sel/an/seg/dp/frame_tick out
module debug_display_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 500000,
    parameter bit LZ_BLANK     = 1'b0
) (
    input logic                 clk,
    input logic                 rst_n,
    debug_display_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [2:0]    sync;
    logic          btn_s;
    logic          btn_stable;
    logic [DW-1:0] db_cnt;
    logic [SW-1:0] presc;
    logic [2:0]    digit;
    logic [31:0]   snap;
    logic          db_done;
    logic          wrap;
    logic          frame_end;
    logic [31:0]   hi;
    logic          blank;
    // Two metastability flops plus one aligning stage: a held press is accepted
    // DEBOUNCE_CYC+2 edges after the edge that first samples it.
    assign btn_s = sync[2];
    always_comb begin
        db_done   = (btn_s != btn_stable) && (db_cnt == DW'(DEBOUNCE_CYC - 1));
        wrap      = presc == SW'(SCAN_DIV - 1);
        frame_end = wrap && (digit == 3'd7);
        hi        = snap >> {digit, 2'b00};
        // Blank a digit when it and every higher nibble are zero; digit 0 always shows.
        blank     = LZ_BLANK && (digit != 3'd0) && (hi == 32'd0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync           <= '0;
            btn_stable     <= 1'b0;
            db_cnt         <= '0;
            bus.view_sel   <= 3'd1;
            presc          <= '0;
            digit          <= 3'd0;
            snap           <= 32'd0;
            bus.frame_tick <= 1'b0;
            bus.an         <= 8'hFF;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
        end else begin
            sync           <= {sync[1:0], bus.btn_next};
            db_cnt         <= (btn_s == btn_stable || db_done) ? '0 : db_cnt + 1'b1;
            if (db_done) btn_stable <= btn_s;
            if (db_done && btn_s) bus.view_sel <= (bus.view_sel == 3'd6) ? 3'd1 : bus.view_sel + 3'd1;
            presc          <= wrap ? '0 : presc + 1'b1;
            if (wrap) digit <= digit + 3'd1;
            // Snapshot only at the frame boundary so a frame never mixes two words.
            if (frame_end) snap <= bus.show_value;
            bus.frame_tick <= frame_end;
            bus.an         <= blank ? 8'hFF : ~(8'h01 << digit);
            bus.seg        <= HEX[hi[3:0]];
            bus.dp         <= digit != bus.view_sel;
        end
    end
endmodule
